// File: rtl/key_pkg.sv
// Shared channel state encoding, 50 MHz timing defaults and counter sizing helper
// for the push-button / slide-switch front end.
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        PRESS_CHECK   = 2'd1,
        PRESSED       = 2'd2,
        RELEASE_CHECK = 2'd3
    } key_state_e;

    localparam int unsigned DEF_CNT_W                = 25;
    localparam int unsigned DEF_DEBOUNCE_CYCLES      = 1_000_000;  // 20 ms at 50 MHz
    localparam int unsigned DEF_REPEAT_DELAY_CYCLES  = 25_000_000; // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD_CYCLES = 5_000_000;  // 100 ms

    // Bits needed to hold max_val; a value fits a W-bit counter iff this is <= W.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((max_val >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One input channel: 2-FF synchronizer, debounce FSM and optional auto-repeat.
// All outputs are registered.
module key_debounce_channel
    import key_pkg::*;
#(
    parameter bit          ACTIVE_LOW           = 1'b0,
    parameter int unsigned CNT_W                = DEF_CNT_W,
    parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY_CYCLES  = 0,
    parameter int unsigned REPEAT_PERIOD_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam bit             RPT_EN      = (REPEAT_DELAY_CYCLES != 0);
    localparam logic           IDLE_LEVEL  = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(REPEAT_PERIOD_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             phase_q, phase_d;
    logic             pressed_q, pressed_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic             repeat_pulse_q, repeat_pulse_d;
    logic             s;

    always_comb begin
        sync_d          = {sync_q[0], raw_in};
        s               = sync_q[1] ^ ACTIVE_LOW;
        state_d         = state_q;
        cnt_d           = cnt_q;
        rpt_cnt_d       = rpt_cnt_q;
        phase_d         = phase_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        repeat_pulse_d  = 1'b0;

        // Counters only ever climb to their *_LAST value before being reloaded,
        // so they cannot wrap as long as the parameters fit CNT_W.
        case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d = PRESS_CHECK;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_CHECK: begin
                if (!s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d       = PRESSED;
                    cnt_d         = '0;
                    rpt_cnt_d     = '0;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_CHECK;
                    cnt_d   = CNT_W'(1);
                end else if (RPT_EN) begin
                    if (rpt_cnt_q == (phase_q ? PER_LAST : DLY_LAST)) begin
                        repeat_pulse_d = 1'b1;
                        rpt_cnt_d      = '0;
                        phase_d        = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
            end
            RELEASE_CHECK: begin
                // rpt_cnt is deliberately held here so a short release bounce
                // does not restart the repeat schedule.
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d         = RELEASED;
                    cnt_d           = '0;
                    rpt_cnt_d       = '0;
                    phase_d         = 1'b0;
                    release_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase

        pressed_d = (state_d == PRESSED) || (state_d == RELEASE_CHECK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q          <= {2{IDLE_LEVEL}};
            state_q         <= RELEASED;
            cnt_q           <= '0;
            rpt_cnt_q       <= '0;
            phase_q         <= 1'b0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            repeat_pulse_q  <= 1'b0;
        end else begin
            sync_q          <= sync_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rpt_cnt_q       <= rpt_cnt_d;
            phase_q         <= phase_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            repeat_pulse_q  <= repeat_pulse_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign repeat_pulse  = repeat_pulse_q;

endmodule

// File: rtl/key_conditioner.sv
// DE1-SoC input front end: debounced key levels/pulses with auto-repeat and
// debounced switch levels, one independent channel per physical input.
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS             = 4,
    parameter int unsigned NUM_SW               = 4,
    parameter int unsigned CNT_W                = DEF_CNT_W,
    parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
    parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_SW-1:0]   sw,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic [NUM_KEYS-1:0] key_press_pulse,
    output logic [NUM_KEYS-1:0] key_release_pulse,
    output logic [NUM_KEYS-1:0] key_repeat_pulse,
    output logic [NUM_SW-1:0]   sw_stable
);

    localparam int unsigned NUM_CH = NUM_KEYS + NUM_SW;

    if (DEBOUNCE_CYCLES < 2 || cnt_width(DEBOUNCE_CYCLES) > CNT_W) begin : g_bad_debounce
        $error("key_conditioner: DEBOUNCE_CYCLES must be in 2..2^CNT_W-1");
    end
    if (cnt_width(REPEAT_DELAY_CYCLES) > CNT_W) begin : g_bad_delay
        $error("key_conditioner: REPEAT_DELAY_CYCLES must be below 2^CNT_W");
    end
    if (REPEAT_PERIOD_CYCLES < 1 || cnt_width(REPEAT_PERIOD_CYCLES) > CNT_W) begin : g_bad_period
        $error("key_conditioner: REPEAT_PERIOD_CYCLES must be in 1..2^CNT_W-1");
    end

    logic [NUM_CH-1:0] pressed_all;
    logic [NUM_CH-1:0] press_all;
    logic [NUM_CH-1:0] release_all;
    logic [NUM_CH-1:0] repeat_all;

    // Channels [0, NUM_KEYS) are active-low keys; the rest are switches with repeat off.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        if (gi < NUM_KEYS) begin : g_key
            key_debounce_channel #(
                .ACTIVE_LOW           (1'b1),
                .CNT_W                (CNT_W),
                .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
                .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
                .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
            ) u_ch (
                .clk           (clk),
                .reset         (reset),
                .raw_in        (key_n[gi]),
                .pressed       (pressed_all[gi]),
                .press_pulse   (press_all[gi]),
                .release_pulse (release_all[gi]),
                .repeat_pulse  (repeat_all[gi])
            );
        end else begin : g_sw
            key_debounce_channel #(
                .ACTIVE_LOW           (1'b0),
                .CNT_W                (CNT_W),
                .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
                .REPEAT_DELAY_CYCLES  (0),
                .REPEAT_PERIOD_CYCLES (1)
            ) u_ch (
                .clk           (clk),
                .reset         (reset),
                .raw_in        (sw[gi-NUM_KEYS]),
                .pressed       (pressed_all[gi]),
                .press_pulse   (press_all[gi]),
                .release_pulse (release_all[gi]),
                .repeat_pulse  (repeat_all[gi])
            );
        end
    end

    assign key_pressed       = pressed_all[NUM_KEYS-1:0];
    assign key_press_pulse   = press_all[NUM_KEYS-1:0];
    assign key_release_pulse = release_all[NUM_KEYS-1:0];
    assign key_repeat_pulse  = repeat_all[NUM_KEYS-1:0];
    assign sw_stable         = pressed_all[NUM_CH-1:NUM_KEYS];

    // Switch channels produce pulses nobody consumes.
    logic [2:0] sw_pulses_unused;
    assign sw_pulses_unused = {|press_all[NUM_CH-1:NUM_KEYS],
                               |release_all[NUM_CH-1:NUM_KEYS],
                               |repeat_all[NUM_CH-1:NUM_KEYS]};

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short timing (debounce 4, delay 10, period 3).
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic [3:0] sw;
    logic [3:0] key_pressed, key_press_pulse, key_release_pulse, key_repeat_pulse;
    logic [3:0] sw_stable;

    int n_tot = 0;
    int n_bad = 0;

    // Event log, indexed by channel; cyc = number of the edge just before sampling.
    int cyc;
    int pr_cnt[4], pr_at[4], rl_cnt[4], rl_at[4];
    int rp_cnt[4], rp_first[4], rp_last[4];
    int kp_first[4], sw_hi_first[4], sw_lo_first[4];

    key_conditioner #(
        .NUM_KEYS             (4),
        .NUM_SW               (4),
        .CNT_W                (8),
        .DEBOUNCE_CYCLES      (4),
        .REPEAT_DELAY_CYCLES  (10),
        .REPEAT_PERIOD_CYCLES (3)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .key_n             (key_n),
        .sw                (sw),
        .key_pressed       (key_pressed),
        .key_press_pulse   (key_press_pulse),
        .key_release_pulse (key_release_pulse),
        .key_repeat_pulse  (key_repeat_pulse),
        .sw_stable         (sw_stable)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (key_press_pulse[b]) begin
                pr_cnt[b] <= pr_cnt[b] + 1;
                pr_at[b]  <= cyc;
            end
            if (key_release_pulse[b]) begin
                rl_cnt[b] <= rl_cnt[b] + 1;
                rl_at[b]  <= cyc;
            end
            if (key_repeat_pulse[b]) begin
                if (rp_cnt[b] == 0) rp_first[b] <= cyc;
                rp_cnt[b]  <= rp_cnt[b] + 1;
                rp_last[b] <= cyc;
            end
            if (key_pressed[b] && kp_first[b] < 0) kp_first[b] <= cyc;
            if (sw_stable[b] && sw_hi_first[b] < 0) sw_hi_first[b] <= cyc;
            if (!sw_stable[b] && sw_lo_first[b] < 0) sw_lo_first[b] <= cyc;
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Inputs change just after a negedge; the next posedge is edge 0 of the window.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic mark();
        cyc = 0;
        for (int b = 0; b < 4; b++) begin
            pr_cnt[b] = 0;  pr_at[b] = -1;
            rl_cnt[b] = 0;  rl_at[b] = -1;
            rp_cnt[b] = 0;  rp_first[b] = -1; rp_last[b] = -1;
            kp_first[b] = -1; sw_hi_first[b] = -1; sw_lo_first[b] = -1;
        end
    endtask

    initial begin
        logic [19:0] acc;
        reset = 1'b1;
        key_n = 4'hF;
        sw    = 4'h0;
        mark();
        cycles(3);
        chk("in_reset_outputs", int'({key_pressed, key_press_pulse, key_release_pulse,
                                      key_repeat_pulse, sw_stable}), 0);

        // Idle after reset: nothing may fire.
        reset = 1'b0;
        acc   = '0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            acc |= {key_pressed, key_press_pulse, key_release_pulse, key_repeat_pulse, sw_stable};
        end
        chk("reset_idle", int'(acc), 0);

        // Key 0: clean press, pulse right after edge 5.
        mark();
        key_n[0] = 1'b0;
        cycles(4);
        chk("k0_not_yet", int'(key_pressed[0]), 0);
        cycles(10);
        chk("k0_press_cnt", pr_cnt[0], 1);
        chk("k0_press_at", pr_at[0], 5);
        chk("k0_level_at", kp_first[0], 5);
        chk("k0_level", int'(key_pressed[0]), 1);
        chk("k0_others", pr_cnt[1] + pr_cnt[2] + pr_cnt[3] + kp_first[1] + kp_first[2] + kp_first[3], -3);

        // Reset mid-press: level drops, then the held key is re-debounced.
        reset = 1'b1;
        cycles(1);
        chk("rst_mid_level", int'(key_pressed[0]), 0);
        reset = 1'b0;
        mark();
        cycles(10);
        chk("rst_repress_cnt", pr_cnt[0], 1);
        chk("rst_repress_at", pr_at[0], 5);

        // Key 0 release: same latency.
        mark();
        key_n[0] = 1'b1;
        cycles(10);
        chk("k0_rel_cnt", rl_cnt[0], 1);
        chk("k0_rel_at", rl_at[0], 5);
        chk("k0_rel_level", int'(key_pressed[0]), 0);

        // Key 1 bounce: 3 low samples never reach the 4 needed.
        mark();
        for (int i = 0; i < 5; i++) begin
            key_n[1] = 1'b0;
            cycles(3);
            key_n[1] = 1'b1;
            cycles(2);
        end
        cycles(10);
        chk("k1_bounce_press", pr_cnt[1], 0);
        chk("k1_bounce_rel", rl_cnt[1], 0);
        chk("k1_bounce_level", kp_first[1], -1);

        // Key 2 held: press 5, repeats 15,18..45, release captured edge 46 -> pulse 51.
        mark();
        key_n[2] = 1'b0;
        cycles(46);
        key_n[2] = 1'b1;
        cycles(30);
        chk("k2_press_at", pr_at[2], 5);
        chk("k2_rpt_first", rp_first[2], 15);
        chk("k2_rpt_last", rp_last[2], 45);
        chk("k2_rpt_cnt", rp_cnt[2], 11);
        chk("k2_rel_cnt", rl_cnt[2], 1);
        chk("k2_rel_at", rl_at[2], 51);
        chk("k2_level_end", int'(key_pressed[2]), 0);

        // Simultaneous presses on keys 0 and 3.
        mark();
        key_n[0] = 1'b0;
        key_n[3] = 1'b0;
        cycles(8);
        chk("sim_k0_at", pr_at[0], 5);
        chk("sim_k3_at", pr_at[3], 5);
        key_n = 4'hF;
        cycles(10);

        // Switch 3: rise after 5 edges, 2-cycle drop ignored, real drop accepted.
        mark();
        sw[3] = 1'b1;
        cycles(10);
        chk("sw3_rise_at", sw_hi_first[3], 5);
        chk("sw_others", int'(sw_stable[2:0]), 0);
        mark();
        sw[3] = 1'b0;
        cycles(2);
        sw[3] = 1'b1;
        cycles(12);
        chk("sw3_glitch", sw_lo_first[3], -1);
        mark();
        sw[3] = 1'b0;
        cycles(10);
        chk("sw3_fall_at", sw_lo_first[3], 5);
        chk("sw_key_quiet", pr_cnt[0] + pr_cnt[1] + pr_cnt[2] + pr_cnt[3], 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
